// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the LEGv8 fetch path.
//   NOP_INSTR : bubble word, ADD XZR,XZR,XZR (no architectural effect)
//   PC_STEP   : sequential fetch increment
//   pc_sel_t  : next-PC source selected each cycle
//   sat_inc32 : saturating 32-bit increment used by the event counters
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h8B1F_03FF;
  localparam logic [63:0] PC_STEP   = 64'd4;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_ID,
    PC_EX,
    PC_HOLD
  } pc_sel_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) return value;
    else                        return value + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, bubble insertion and synchronous reset.
// Ports:
//   clk, reset (sync, active-low)
//   hold          : keep all fields (ignored when bubble is high)
//   bubble        : load NOP_INSTR with valid=0, tagged with fetch_pc
//   fetch_pc      : PC of the word being fetched this cycle
//   fetch_instr   : word returned by instruction memory
//   if_PC, if_instruction, if_valid : registered outputs toward decode
module if_id_reg #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h8B1F_03FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic [63:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  output logic [63:0] if_PC,
  output logic [31:0] if_instruction,
  output logic        if_valid
);

  // Bubble beats hold: an execute redirect must squash even a stalled ID slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_PC          <= RESET_PC;
      if_instruction <= NOP_INSTR;
      if_valid       <= 1'b0;
    end else if (bubble) begin
      if_PC          <= fetch_pc;
      if_instruction <= NOP_INSTR;
      if_valid       <= 1'b0;
    end else if (!hold) begin
      if_PC          <= fetch_pc;
      if_instruction <= fetch_instr;
      if_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register
// and fetch/flush event counters.
// Ports:
//   clk, reset (sync, active-low)
//   stall                               : hold PC and IF/ID
//   id_branch_taken / id_branch_target  : unconditional redirect from decode
//   ex_branch_taken / ex_branch_target  : conditional/BR redirect from execute
//   imem_addr / imem_rdata              : asynchronous instruction memory
//   if_PC, if_instruction, if_valid     : IF/ID register toward decode
//   fetch_count, flush_count            : saturating event counters
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h8B1F_03FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_branch_taken,
  input  logic [63:0] id_branch_target,
  input  logic        ex_branch_taken,
  input  logic [63:0] ex_branch_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [63:0] if_PC,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  import cpu_pkg::*;

  logic [63:0] pc;
  logic [63:0] pc_next;
  pc_sel_t     pc_sel;
  logic        redirect;
  logic        hold;
  logic        accept;

  // Execute redirect outranks the stall because the stalled ID instruction
  // is younger than the branch; a decode redirect waits out the stall.
  always_comb begin
    pc_sel = PC_SEQ;
    if (ex_branch_taken)      pc_sel = PC_EX;
    else if (stall)           pc_sel = PC_HOLD;
    else if (id_branch_taken) pc_sel = PC_ID;
  end

  always_comb begin
    pc_next = pc + PC_STEP;
    unique case (pc_sel)
      PC_EX:   pc_next = ex_branch_target;
      PC_ID:   pc_next = id_branch_target;
      PC_HOLD: pc_next = pc;
      default: pc_next = pc + PC_STEP;
    endcase
  end

  assign redirect  = (pc_sel == PC_EX) || (pc_sel == PC_ID);
  assign hold      = (pc_sel == PC_HOLD);
  assign accept    = (pc_sel == PC_SEQ);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      fetch_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      pc <= pc_next;
      if (accept)   fetch_count <= sat_inc32(fetch_count);
      if (redirect) flush_count <= sat_inc32(flush_count);
    end
  end

  if_id_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .bubble         (redirect),
    .fetch_pc       (pc),
    .fetch_instr    (imem_rdata),
    .if_PC          (if_PC),
    .if_instruction (if_instruction),
    .if_valid       (if_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h8B1F_03FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        id_branch_taken;
  logic [63:0] id_branch_target;
  logic        ex_branch_taken;
  logic [63:0] ex_branch_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] if_PC;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  int total_checks = 0;
  int fail_checks  = 0;

  // Reference state
  logic [63:0] m_pc;
  logic [63:0] m_if_pc;
  logic [31:0] m_if_ins;
  logic        m_if_valid;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [63:0] addr);
    return addr[31:0] ^ addr[63:32] ^ 32'h5A00_0000;
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .id_branch_taken  (id_branch_taken),
    .id_branch_target (id_branch_target),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .if_PC            (if_PC),
    .if_instruction   (if_instruction),
    .if_valid         (if_valid),
    .fetch_count      (fetch_count),
    .flush_count      (flush_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_checks++;
    assert (obs === exp)
    else begin
      fail_checks++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Cycle-level rules of the fetch stage applied to the reference state.
  task automatic model_edge(input logic rst_n, input logic st, input logic idb,
                            input logic [63:0] idt, input logic exb,
                            input logic [63:0] ext);
    if (!rst_n) begin
      m_pc = 64'h0; m_if_pc = 64'h0; m_if_ins = NOP; m_if_valid = 1'b0;
      m_fetch = 32'd0; m_flush = 32'd0;
    end else if (exb) begin
      m_if_pc = m_pc; m_if_ins = NOP; m_if_valid = 1'b0;
      m_flush = sat(m_flush); m_pc = ext;
    end else if (st) begin
      // everything holds
    end else if (idb) begin
      m_if_pc = m_pc; m_if_ins = NOP; m_if_valid = 1'b0;
      m_flush = sat(m_flush); m_pc = idt;
    end else begin
      m_if_pc = m_pc; m_if_ins = imem_word(m_pc); m_if_valid = 1'b1;
      m_fetch = sat(m_fetch); m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic check_all();
    chk("pc",          imem_addr,      m_pc);
    chk("if_PC",       if_PC,          m_if_pc);
    chk("if_instr",    {32'h0, if_instruction}, {32'h0, m_if_ins});
    chk("if_valid",    {63'h0, if_valid},       {63'h0, m_if_valid});
    chk("fetch_count", {32'h0, fetch_count},    {32'h0, m_fetch});
    chk("flush_count", {32'h0, flush_count},    {32'h0, m_flush});
  endtask

  task automatic step(input logic rst_n, input logic st, input logic idb,
                      input logic [63:0] idt, input logic exb, input logic [63:0] ext);
    reset = rst_n; stall = st;
    id_branch_taken = idb; id_branch_target = idt;
    ex_branch_taken = exb; ex_branch_target = ext;
    @(posedge clk);
    model_edge(rst_n, st, idb, idt, exb, ext);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0;
    id_branch_taken = 1'b0; id_branch_target = 64'h0;
    ex_branch_taken = 1'b0; ex_branch_target = 64'h0;
    #2;

    // Reset, then four free-running fetches
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    chk("rst_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_instr", {32'h0, if_instruction}, {32'h0, NOP});
    idle(4);
    chk("free_if_pc", if_PC, 64'd12);
    chk("free_fetch", {32'h0, fetch_count}, 64'd4);

    // Stall at pc=8 with PC 4 held in IF/ID
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
    chk("stall_pc", imem_addr, 64'd8);
    chk("stall_if_pc", if_PC, 64'd4);
    idle(1);
    chk("resume_if_pc", if_PC, 64'd8);

    // Decode redirect to 0x100
    step(1'b1, 1'b0, 1'b1, 64'h100, 1'b0, 64'h0);
    chk("id_bubble", {63'h0, if_valid}, 64'h0);
    idle(1);
    chk("id_target", if_PC, 64'h100);

    // Both redirects under stall: execute target wins, one bubble
    step(1'b1, 1'b1, 1'b1, 64'h200, 1'b1, 64'h40);
    chk("ex_pc", imem_addr, 64'h40);
    idle(1);

    // Decode redirect held off by stall, then taken
    step(1'b1, 1'b1, 1'b1, 64'h300, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b1, 64'h300, 1'b0, 64'h0);
    chk("id_late_pc", imem_addr, 64'h300);

    // Reset during a stall at pc=0x40
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h40);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b1, 64'h500, 1'b1, 64'h600);
    chk("midrst_pc", imem_addr, 64'h0);
    chk("midrst_flush", {32'h0, flush_count}, 64'h0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic        r, s, ib, eb;
      logic [63:0] it, et;
      r  = ($urandom_range(0, 59) != 0);
      s  = ($urandom_range(0, 3) == 0);
      ib = ($urandom_range(0, 5) == 0);
      eb = ($urandom_range(0, 7) == 0);
      it = {$urandom(), $urandom()};
      et = {$urandom(), $urandom()};
      step(r, s, ib, it, eb, et);
    end

    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule
